// File: rtl/seg_chase_pkg.sv
// Shared types and constants for the seven-segment fading chaser.
package seg_chase_pkg;

  localparam int POS_W   = 3;
  localparam int SEG_W   = 3;
  localparam int NUM_POS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ACK  = 2'd2
  } chase_state_t;

  // Figure-8 walk: position 0 is the least significant entry.
  // pos: 0->0, 1->1, 2->6, 3->4, 4->3, 5->2, 6->6, 7->5
  localparam logic [NUM_POS*SEG_W-1:0] PATTERN = {
    3'd5, 3'd6, 3'd2, 3'd3, 3'd4, 3'd6, 3'd1, 3'd0
  };

  // Map a pattern position to the segment it lights.
  function automatic logic [SEG_W-1:0] pattern_seg(input logic [POS_W-1:0] p);
    return PATTERN[int'(p)*SEG_W +: SEG_W];
  endfunction

endpackage

// File: rtl/seg_chase_sequencer_timer.sv
// Step-period timer: latches speed at step boundaries so a speed change
// never shortens or stretches the period already in progress.
import seg_chase_pkg::*;

module seg_step_timer #(
  parameter int STEP_BASE_W = 21
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       restart,
  input  logic [2:0] speed,
  output logic       step
);

  localparam int CNT_W = STEP_BASE_W + 3;

  logic [2:0]       speed_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] threshold;

  // Higher speed means a smaller top field, hence a shorter period.
  assign threshold = {~speed_q, {STEP_BASE_W{1'b1}}};
  assign step      = enable && (count_q == threshold);

  // Count while enabled; restart and each step boundary re-latch speed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      speed_q <= '0;
    end else if (restart) begin
      count_q <= '0;
      speed_q <= speed;
    end else if (enable) begin
      if (step) begin
        count_q <= '0;
        speed_q <= speed;
      end else begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seg_chase_sequencer.sv
// Chaser controller: position sequencing, run/idle/single-step control,
// plus the free-running fade tick and PWM phase for the segment bank.
import seg_chase_pkg::*;

module seg_chase_sequencer #(
  parameter int STEP_BASE_W = 21,
  parameter int FADE_W      = 21,
  parameter int PWM_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             direction,
  input  logic [2:0]       speed,
  input  logic             step_req,
  output logic             step_ack,
  output logic [SEG_W-1:0] seg_sel,
  output logic             seg_load,
  output logic             fade_tick,
  output logic [4:0]       pwm_phase,
  output logic [POS_W-1:0] pos
);

  chase_state_t     state_q;
  chase_state_t     next_state;
  logic             advance;
  logic             timer_enable;
  logic             timer_step;
  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] pos_next;
  logic [FADE_W-1:0] fade_cnt_q;
  logic [PWM_W-1:0]  pwm_cnt_q;

  // The timer only runs in RUN with run still high; anywhere else it is
  // held at zero and keeps sampling speed, so RUN entry starts fresh.
  assign timer_enable = (state_q == RUN) && run;

  seg_step_timer #(
    .STEP_BASE_W(STEP_BASE_W)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (timer_enable),
    .restart(!timer_enable),
    .speed  (speed),
    .step   (timer_step)
  );

  // 3-bit position wraps naturally in both directions.
  assign pos_next = direction ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));

  // Next-state and advance decision; a step request beats run in IDLE.
  always_comb begin
    next_state = state_q;
    advance    = 1'b0;
    case (state_q)
      IDLE: begin
        if (step_req) begin
          advance    = 1'b1;
          next_state = ACK;
        end else if (run) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (!run) begin
          next_state = IDLE;
        end else if (timer_step) begin
          advance = 1'b1;
        end
      end
      ACK: begin
        if (!step_req) begin
          next_state = run ? RUN : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State, position and registered strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      seg_sel  <= '0;
      seg_load <= 1'b0;
      step_ack <= 1'b0;
    end else begin
      state_q  <= next_state;
      seg_load <= advance;
      step_ack <= (next_state == ACK);
      if (advance) begin
        pos_q   <= pos_next;
        seg_sel <= pattern_seg(pos_next);
      end
    end
  end

  // Free-running fade counter; tick marks the cycle after it wraps to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fade_cnt_q <= '0;
      fade_tick  <= 1'b0;
    end else begin
      fade_cnt_q <= fade_cnt_q + FADE_W'(1);
      fade_tick  <= &fade_cnt_q;
    end
  end

  // Free-running PWM counter; its top five bits form the compare phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
    end
  end

  assign pwm_phase = pwm_cnt_q[PWM_W-1 -: 5];
  assign pos       = pos_q;

endmodule

// File: tb/tb_seg_chase_sequencer.sv
// Directed bench for the chaser controller with small counter widths.
module tb_seg_chase_sequencer;

  logic       clk;
  logic       reset_n;
  logic       run;
  logic       direction;
  logic [2:0] speed;
  logic       step_req;
  logic       step_ack;
  logic [2:0] seg_sel;
  logic       seg_load;
  logic       fade_tick;
  logic [4:0] pwm_phase;
  logic [2:0] pos;

  int checks;
  int errors;
  int ec;

  seg_chase_sequencer #(
    .STEP_BASE_W(2),
    .FADE_W     (4),
    .PWM_W      (6)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .direction(direction),
    .speed    (speed),
    .step_req (step_req),
    .step_ack (step_ack),
    .seg_sel  (seg_sel),
    .seg_load (seg_load),
    .fade_tick(fade_tick),
    .pwm_phase(pwm_phase),
    .pos      (pos)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One rising edge, then settle; ec counts edges since reset release.
  task automatic step_clock();
    @(posedge clk);
    #1;
    ec++;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_step(input string tag, input logic load,
                            input logic [2:0] p, input logic [2:0] s);
    check_output({tag, "_load"}, 32'(seg_load), 32'(load));
    check_output({tag, "_pos"},  32'(pos),      32'(p));
    check_output({tag, "_sel"},  32'(seg_sel),  32'(s));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_pos"},  32'(pos),       32'd0);
    check_output({tag, "_sel"},  32'(seg_sel),   32'd0);
    check_output({tag, "_load"}, 32'(seg_load),  32'd0);
    check_output({tag, "_ack"},  32'(step_ack),  32'd0);
    check_output({tag, "_fade"}, 32'(fade_tick), 32'd0);
    check_output({tag, "_pwm"},  32'(pwm_phase), 32'd0);
  endtask

  logic [2:0] fwd_seg [7];
  logic [2:0] fwd_pos [7];

  initial begin
    checks = 0;
    errors = 0;
    ec     = 0;
    fwd_seg = '{3'd6, 3'd4, 3'd3, 3'd2, 3'd6, 3'd5, 3'd0};
    fwd_pos = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

    reset_n   = 1'b0;
    run       = 1'b0;
    direction = 1'b1;
    speed     = 3'd7;
    step_req  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    #2;
    reset_n = 1'b1;
    run     = 1'b1;
    ec      = 0;

    // Edge 1 enters RUN; timer counts 0..3, first advance on edge 5.
    for (int i = 1; i <= 4; i++) begin
      step_clock();
      check_output("first_wait_load", 32'(seg_load), 32'd0);
    end
    step_clock();
    check_step("first_step", 1'b1, 3'd1, 3'd1);

    // Forward walk, one step every 4 cycles.
    for (int i = 0; i < 7; i++) begin
      repeat (3) step_clock();
      check_output("fwd_gap_load", 32'(seg_load), 32'd0);
      step_clock();
      check_step("fwd_step", 1'b1, fwd_pos[i], fwd_seg[i]);
    end

    // Speed 7->6 mid-period: current period stays 4, next one is 8.
    step_clock();
    speed = 3'd6;
    repeat (2) step_clock();
    check_output("spd_cur_gap", 32'(seg_load), 32'd0);
    step_clock();
    check_step("spd_cur_step", 1'b1, 3'd1, 3'd1);
    repeat (7) step_clock();
    check_output("spd_next_gap", 32'(seg_load), 32'd0);
    step_clock();
    check_step("spd_next_step", 1'b1, 3'd2, 3'd6);

    // Drop run just before the threshold edge: no advance, go IDLE.
    repeat (7) step_clock();
    run = 1'b0;
    step_clock();
    check_step("rundrop", 1'b0, 3'd2, 3'd6);
    repeat (2) step_clock();
    check_step("idle_hold", 1'b0, 3'd2, 3'd6);

    // Single-step handshake held for 5 cycles.
    step_req = 1'b1;
    step_clock();
    check_step("hs_step", 1'b1, 3'd3, 3'd4);
    check_output("hs_ack", 32'(step_ack), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step_clock();
      check_output("hs_hold_load", 32'(seg_load), 32'd0);
      check_output("hs_hold_ack",  32'(step_ack), 32'd1);
    end
    step_req = 1'b0;
    step_clock();
    check_output("hs_release_ack", 32'(step_ack), 32'd0);
    repeat (2) step_clock();
    check_step("hs_idle", 1'b0, 3'd3, 3'd4);

    // run and step_req together in IDLE: the step wins.
    run      = 1'b1;
    step_req = 1'b1;
    step_clock();
    check_step("sim_step", 1'b1, 3'd4, 3'd3);
    check_output("sim_ack", 32'(step_ack), 32'd1);
    repeat (2) step_clock();
    check_step("sim_hold", 1'b0, 3'd4, 3'd3);
    check_output("sim_hold_ack", 32'(step_ack), 32'd1);
    step_req = 1'b0;
    step_clock();
    check_output("sim_release_ack", 32'(step_ack), 32'd0);

    // RUN entered on that edge; a step request in RUN is ignored.
    step_clock();
    step_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_clock();
      check_output("run_req_ack",  32'(step_ack), 32'd0);
      check_output("run_req_load", 32'(seg_load), 32'd0);
    end
    step_req = 1'b0;
    repeat (3) step_clock();
    check_output("run_gap_load", 32'(seg_load), 32'd0);
    step_clock();
    check_step("run_step", 1'b1, 3'd5, 3'd2);

    // Free-running counters checked against edge count since release.
    for (int i = 0; i < 21; i++) begin
      step_clock();
      check_output("fade_tick", 32'(fade_tick), 32'((ec % 16) == 0));
      check_output("pwm_phase", 32'(pwm_phase), 32'((ec >> 1) & 31));
    end

    // Get into ACK, then assert reset mid-cycle.
    run      = 1'b0;
    step_req = 1'b1;
    step_clock();
    step_clock();
    check_output("pre_rst_ack", 32'(step_ack), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    #3;
    reset_n   = 1'b1;
    direction = 1'b0;
    ec        = 0;

    // Held step_req after release: fresh advance, reverse wraps 0->7.
    step_clock();
    check_step("rev_wrap", 1'b1, 3'd7, 3'd5);
    check_output("rev_ack", 32'(step_ack), 32'd1);
    step_req = 1'b0;
    step_clock();
    check_output("rev_ack_drop", 32'(step_ack), 32'd0);
    run   = 1'b1;
    speed = 3'd7;
    repeat (4) step_clock();
    check_output("rev_gap_load", 32'(seg_load), 32'd0);
    step_clock();
    check_step("rev_step", 1'b1, 3'd6, 3'd6);
    check_output("rev_pwm", 32'(pwm_phase), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
